lsu_inbuf: RTL and testbench
============================

Name: lsu_inbuf

Overview:
- Memory-mapped input peripheral for the load/store unit: the CPU reads board inputs through it; it is the read-side counterpart of the LED output buffer.
- Synchronizes and debounces 18 slide switches and 4 active-low push keys.
- Latches key-press events into write-1-to-clear flags, counts presses and raises an interrupt.
- Presents a 16-byte register window to the LSU, using the same st_en/datamode/addr/data_in convention as the other LSU peripherals.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a synchronized input bit is accepted (≥2).
- SW_W, 18, number of switch inputs (≤32).
- KEY_W, 4, number of key inputs (≤8).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- st_en  in  1  store enable from LSU
- datamode  in  3  access size: 0 = byte, 1 = half-word, other = word
- addr  in  4  byte address within the 16-byte window
- data_in  in  32  store data
- sw_i  in  SW_W  raw switch levels, asynchronous
- key_ni  in  KEY_W  raw keys, active-low (0 = pressed), asynchronous
- data_o  out  32  load data
- irq_o  out  1  high while any press flag is set

Behaviour:
- Reset (asynchronous, rst_ni low):
  - Synchronizer flops: switches to 0, keys to released.
  - Debounced values, debounce counters, flags and press counter all clear to 0.
  - data_o reflects the cleared registers; irq_o = 0.
- Synchronizer: 2-flop chain per bit. Key bits are inverted after synchronization, so internally pressed = 1.
- Debounce, per bit:
  - When the synchronized value equals the stable value, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable value takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable value.
  - Latency from raw input edge to stable change is 2 + DEBOUNCE_CYCLES cycles.
- Register map (bytes; unused bits read 0):
  - 0x0-0x3: debounced switches, zero-extended. Read-only.
  - 0x4-0x7: debounced keys, pressed = 1. Read-only.
  - 0x8-0xB: press flags, byte 0x8 bits[KEY_W-1:0]. Write-1-to-clear.
  - 0xC-0xF: press counter, 8-bit at byte 0xC. Any write touching byte 0xC clears it.
- Press event: a debounced key bit goes 0→1. On that same clock edge the flag bit sets and the counter adds the number of simultaneous events (0..KEY_W), wrapping mod 256. Releases generate nothing.
- Writes:
  - Bytes are addressed as addr, addr+1, addr+2, addr+3, limited by datamode, with 4-bit wrap-around (e.g. a word at 0xE touches 0xE, 0xF, 0x0, 0x1).
  - Writes to read-only bytes are ignored.
  - A write with st_en=0 has no effect.
- Collisions:
  - Flag clear and new event for the same bit in the same cycle: set wins.
  - Counter clear and events in the same cycle: counter = number of new events.
- Reads: combinational.
  - Raw value = {byte[addr+3], byte[addr+2], byte[addr+1], byte[addr]}, using 4-bit wrap.
  - Masked by datamode: byte → [7:0], half → [15:0], word → full. Zero-extended.
  - Reads have no side effects.
- irq_o: registered OR of the flags, so it follows the flag register with zero added latency.
- Reset asserted mid-debounce or mid-write: all state returns to reset values immediately. No event is generated by the return to released/zero after reset.

Test Plan:
- Reset with key_ni=4'hF, sw_i=0 → word reads at 0x0, 0x4, 0x8, 0xC all return 0; irq_o=0.
- DEBOUNCE_CYCLES=4; sw_i=18'h2A5A5 held → word read at 0x0 = 32'h0002A5A5 exactly 6 cycles after the change, and 0 before that.
- key_ni[2] low for 3 cycles, then high → no change at 0x4; flags 0; counter 0.
- key_ni=4'b1010 held → 0x4 reads 32'h5 and 0x8 reads 32'h5; counter = 2; irq_o=1. Store byte 0x01 to 0x8 → flags 4'h4, irq_o still 1. Store 0x04 → irq_o=0.
- W1C on bit0 in the same cycle a new key0 press debounces → flag bit0 stays 1. Counter at 255 plus one press → reads 0.
- Byte read at 0x1 with sw=18'h3_1234 → 32'h12. Half read at 0xF → {byte0x0, byte0xF}. Word write to 0x4 → no register change.

Source files
------------

// File: rtl/lsu_inbuf.sv
// LSU input peripheral: synchronizes and debounces switches and active-low keys,
// latches key presses into write-1-to-clear flags, counts presses and raises irq_o.
module lsu_inbuf #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_W            = 18,
    parameter int KEY_W           = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             st_en,
    input  logic [2:0]       datamode,
    input  logic [3:0]       addr,
    input  logic [31:0]      data_in,
    input  logic [SW_W-1:0]  sw_i,
    input  logic [KEY_W-1:0] key_ni,
    output logic [31:0]      data_o,
    output logic             irq_o
);

    localparam int               IN_W    = SW_W + KEY_W;
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]             sw_meta_q, sw_sync_q;
    logic [KEY_W-1:0]            key_meta_q, key_sync_q;
    logic [IN_W-1:0]             in_sync;
    logic [IN_W-1:0]             stab_q, stab_d;
    logic [IN_W-1:0][CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [KEY_W-1:0]            key_stab_q, key_stab_d, key_rise;
    logic [KEY_W-1:0]            flag_q, flag_d, flag_clr;
    logic [7:0]                  press_q, press_d, n_ev;
    logic                        irq_q, cnt_clr;
    logic [3:0]                  lane_mask;
    logic [127:0]                reg_img;
    logic [31:0]                 rd_raw, rd_mask;
    logic                        unused_data;

    // Keys are inverted after the synchronizer so that pressed = 1 internally.
    assign in_sync    = {~key_sync_q, sw_sync_q};
    assign key_stab_q = stab_q[IN_W-1:SW_W];
    assign key_stab_d = stab_d[IN_W-1:SW_W];
    assign key_rise   = key_stab_d & ~key_stab_q;
    assign unused_data = ^data_in;

    always_comb begin
        stab_d = stab_q;
        dcnt_d = dcnt_q;
        for (int i = 0; i < IN_W; i++) begin
            if (in_sync[i] == stab_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == CNT_MAX) begin
                stab_d[i] = in_sync[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        case (datamode)
            3'd0:    lane_mask = 4'b0001;
            3'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // Each active lane k hits byte addr+k with 4-bit wrap; only 0x8 and 0xC are writable.
    always_comb begin
        flag_clr = '0;
        cnt_clr  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (st_en && lane_mask[k]) begin
                if (4'(addr + 4'(k)) == 4'h8) begin
                    flag_clr = flag_clr | data_in[8*k +: KEY_W];
                end
                if (4'(addr + 4'(k)) == 4'hC) begin
                    cnt_clr = 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_ev = 8'd0;
        for (int i = 0; i < KEY_W; i++) begin
            n_ev = n_ev + 8'(key_rise[i]);
        end
        flag_d  = (flag_q & ~flag_clr) | key_rise;
        press_d = (cnt_clr ? 8'd0 : press_q) + n_ev;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= '1;
            key_sync_q <= '1;
            stab_q     <= '0;
            dcnt_q     <= '0;
            flag_q     <= '0;
            press_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            sw_meta_q  <= sw_i;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= key_ni;
            key_sync_q <= key_meta_q;
            stab_q     <= stab_d;
            dcnt_q     <= dcnt_d;
            flag_q     <= flag_d;
            press_q    <= press_d;
            irq_q      <= |flag_d;
        end
    end

    assign irq_o = irq_q;

    always_comb begin
        reg_img               = '0;
        reg_img[SW_W-1:0]     = stab_q[SW_W-1:0];
        reg_img[32 +: KEY_W]  = key_stab_q;
        reg_img[64 +: KEY_W]  = flag_q;
        reg_img[96 +: 8]      = press_q;
        rd_raw = '0;
        for (int k = 0; k < 4; k++) begin
            rd_raw[8*k +: 8] = reg_img[{4'(addr + 4'(k)), 3'b000} +: 8];
        end
        rd_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    end

    assign data_o = rd_raw & rd_mask;

endmodule

// File: tb/tb_lsu_inbuf.sv
// Directed bench for lsu_inbuf with a short debounce window: read-map table,
// debounce latency/glitch checks, W1C and counter collision sequences, reset.
module tb_lsu_inbuf;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        st_en = 1'b0;
    logic [2:0]  datamode = 3'd2;
    logic [3:0]  addr = 4'h0;
    logic [31:0] data_in = 32'h0;
    logic [17:0] sw_i = 18'h0;
    logic [3:0]  key_ni = 4'hF;
    logic [31:0] data_o;
    logic        irq_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  dm;
        logic [3:0]  a;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t vecs[13];

    lsu_inbuf #(.DEBOUNCE_CYCLES(4), .SW_W(18), .KEY_W(4)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .st_en    (st_en),
        .datamode (datamode),
        .addr     (addr),
        .data_in  (data_in),
        .sw_i     (sw_i),
        .key_ni   (key_ni),
        .data_o   (data_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [2:0] dm, input logic [3:0] a,
                          input logic [31:0] exp);
        datamode = dm;
        addr     = a;
        #1;
        chk(name, data_o, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Called at a negedge; drives one store across the next posedge.
    task automatic store(input logic [2:0] dm, input logic [3:0] a, input logic [31:0] d);
        st_en    = 1'b1;
        datamode = dm;
        addr     = a;
        data_in  = d;
        @(posedge clk_i);
        @(negedge clk_i);
        st_en   = 1'b0;
        data_in = 32'h0;
    endtask

    task automatic press(input logic [3:0] k);
        key_ni = k;
        wait_cyc(8);
        key_ni = 4'hF;
        wait_cyc(8);
    endtask

    initial begin
        vecs[0]  = '{3'd2, 4'h0, 32'h0003_1234, "tbl_w0"};
        vecs[1]  = '{3'd0, 4'h1, 32'h0000_0012, "tbl_b1"};
        vecs[2]  = '{3'd1, 4'h1, 32'h0000_0312, "tbl_h1"};
        vecs[3]  = '{3'd2, 4'h4, 32'h0000_0005, "tbl_w4"};
        vecs[4]  = '{3'd2, 4'h8, 32'h0000_0000, "tbl_w8"};
        vecs[5]  = '{3'd2, 4'hC, 32'h0000_0002, "tbl_wC"};
        vecs[6]  = '{3'd1, 4'hF, 32'h0000_3400, "tbl_hF"};
        vecs[7]  = '{3'd2, 4'hE, 32'h1234_0000, "tbl_wE"};
        vecs[8]  = '{3'd2, 4'h2, 32'h0005_0003, "tbl_w2"};
        vecs[9]  = '{3'd5, 4'hD, 32'h3400_0000, "tbl_dm5_D"};
        vecs[10] = '{3'd0, 4'hC, 32'h0000_0002, "tbl_bC"};
        vecs[11] = '{3'd1, 4'hB, 32'h0000_0200, "tbl_hB"};
        vecs[12] = '{3'd7, 4'h3, 32'h0000_0500, "tbl_dm7_3"};

        // Reset state
        #12;
        rd_chk("rst_w0", 3'd2, 4'h0, 32'h0);
        rd_chk("rst_w4", 3'd2, 4'h4, 32'h0);
        rd_chk("rst_w8", 3'd2, 4'h8, 32'h0);
        rd_chk("rst_wC", 3'd2, 4'hC, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_cyc(3);

        // Switch latency: 2 sync + 4 debounce cycles
        sw_i = 18'h2A5A5;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk_i);
            #1;
            rd_chk($sformatf("sw_lat_c%0d", c), 3'd2, 4'h0, (c < 6) ? 32'h0 : 32'h0002_A5A5);
        end
        @(negedge clk_i);

        // 3-cycle key glitch must be filtered
        key_ni = 4'b1011;
        wait_cyc(3);
        key_ni = 4'hF;
        wait_cyc(10);
        rd_chk("glitch_keys", 3'd2, 4'h4, 32'h0);
        rd_chk("glitch_flags", 3'd2, 4'h8, 32'h0);
        rd_chk("glitch_cnt", 3'd2, 4'hC, 32'h0);

        // Two keys pressed together
        key_ni = 4'b1010;
        wait_cyc(10);
        rd_chk("press_keys", 3'd2, 4'h4, 32'h5);
        rd_chk("press_flags", 3'd2, 4'h8, 32'h5);
        rd_chk("press_cnt", 3'd2, 4'hC, 32'h2);
        chk("press_irq", {31'h0, irq_o}, 32'h1);
        store(3'd0, 4'h8, 32'h01);
        rd_chk("w1c_b0_flags", 3'd2, 4'h8, 32'h4);
        chk("w1c_b0_irq", {31'h0, irq_o}, 32'h1);
        store(3'd0, 4'h8, 32'h04);
        rd_chk("w1c_b2_flags", 3'd2, 4'h8, 32'h0);
        chk("w1c_b2_irq", {31'h0, irq_o}, 32'h0);

        // Read-map table
        sw_i = 18'h3_1234;
        wait_cyc(8);
        foreach (vecs[i]) rd_chk(vecs[i].name, vecs[i].dm, vecs[i].a, vecs[i].exp);

        // Writes to read-only bytes are ignored
        store(3'd2, 4'h4, 32'hFFFF_FFFF);
        rd_chk("ro_w4", 3'd2, 4'h4, 32'h5);
        rd_chk("ro_w0", 3'd2, 4'h0, 32'h0003_1234);
        rd_chk("ro_cnt", 3'd2, 4'hC, 32'h2);

        // W1C on bit0 on the same edge key0 press debounces: set wins
        key_ni = 4'hF;
        wait_cyc(10);
        key_ni = 4'b1110;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        store(3'd0, 4'h8, 32'h01);
        rd_chk("coll_w1c_flags", 3'd2, 4'h8, 32'h1);
        rd_chk("coll_w1c_cnt", 3'd2, 4'hC, 32'h3);
        chk("coll_w1c_irq", {31'h0, irq_o}, 32'h1);

        // Store with st_en low has no effect; release generates nothing
        datamode = 3'd2; addr = 4'h8; data_in = 32'hFF;
        wait_cyc(1);
        data_in = 32'h0;
        key_ni = 4'hF;
        wait_cyc(10);
        rd_chk("noen_flags", 3'd2, 4'h8, 32'h1);
        rd_chk("release_cnt", 3'd2, 4'hC, 32'h3);

        // Counter clear on the same edge as key1 press: counter = 1
        key_ni = 4'b1101;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        store(3'd2, 4'hC, 32'h0);
        rd_chk("coll_clr_cnt", 3'd2, 4'hC, 32'h1);
        rd_chk("coll_clr_flags", 3'd2, 4'h8, 32'h3);
        key_ni = 4'hF;
        wait_cyc(10);

        // Half store at 0xB reaches 0xC via the lane wrap
        store(3'd1, 4'hB, 32'h0);
        rd_chk("half_b_cnt", 3'd2, 4'hC, 32'h0);
        rd_chk("half_b_flags", 3'd2, 4'h8, 32'h3);

        // Counter wrap: 63*4 + 3 = 255, then one more press -> 0
        for (int p = 0; p < 63; p++) press(4'b0000);
        press(4'b1000);
        rd_chk("cnt_255", 3'd2, 4'hC, 32'hFF);
        press(4'b1110);
        rd_chk("cnt_wrap", 3'd2, 4'hC, 32'h0);
        rd_chk("wrap_flags", 3'd2, 4'h8, 32'hF);

        // Reset mid-debounce
        key_ni = 4'b1110;
        wait_cyc(3);
        #2 rst_ni = 1'b0;
        rd_chk("mid_rst_flags", 3'd2, 4'h8, 32'h0);
        rd_chk("mid_rst_sw", 3'd2, 4'h0, 32'h0);
        chk("mid_rst_irq", {31'h0, irq_o}, 32'h0);
        key_ni = 4'hF;
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_cyc(10);
        rd_chk("post_rst_flags", 3'd2, 4'h8, 32'h0);
        rd_chk("post_rst_cnt", 3'd2, 4'hC, 32'h0);
        rd_chk("post_rst_keys", 3'd2, 4'h4, 32'h0);
        rd_chk("post_rst_sw", 3'd2, 4'h0, 32'h0003_1234);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
